// File: rtl/serial_frame_deserializer_if.sv
// Serial-in / word-out bundle for serial_frame_deserializer.
// slave = deserializer side, master = stream source plus downstream consumer.
interface serial_frame_deserializer_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
);
    logic                 din;
    logic                 din_en;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  din, din_en, dout_ready,
        output dout, dout_valid, frame_err, parity_err, overrun, err_count
    );

    modport master (
        output din, din_en, dout_ready,
        input  dout, dout_valid, frame_err, parity_err, overrun, err_count
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Framed serial-to-parallel deserializer with one-entry valid/ready output and error counting.
// Optional even-parity bit after the data bits is enabled by defining DESER_PARITY_EN.
module serial_frame_deserializer #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_frame_deserializer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     shreg;
    logic                 par_bad;

    logic [WIDTH-1:0]     dout_r;
    logic                 dout_valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic [ERR_CNT_W-1:0] err_count_r;

    logic                 stop_smp, out_free;
    logic                 ev_fe, ev_pe, ev_ov, ev_load;
    logic [1:0]           ev_n;
    logic [ERR_CNT_W:0]   err_sum;
    logic [ERR_CNT_W-1:0] err_next;

    // All completion decisions are made on the edge that samples the stop bit.
    always_comb begin
        stop_smp = bus.din_en && (state == STOP);
        out_free = !dout_valid_r || bus.dout_ready;
        ev_fe    = stop_smp && !bus.din;
        ev_pe    = stop_smp && par_bad;
        ev_load  = stop_smp && bus.din && !par_bad && out_free;
        ev_ov    = stop_smp && bus.din && !par_bad && !out_free;
        ev_n     = {1'b0, ev_fe} + {1'b0, ev_pe} + {1'b0, ev_ov};
        err_sum  = {1'b0, err_count_r} + (ERR_CNT_W+1)'(ev_n);
        err_next = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
    end

`ifdef DESER_PARITY_EN
    logic parity_err_r;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            err_count_r  <= '0;
`ifdef DESER_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= ev_fe;
            overrun_r   <= ev_ov;
            err_count_r <= err_next;
`ifdef DESER_PARITY_EN
            parity_err_r <= ev_pe;
`endif
            if (ev_load) begin
                dout_r       <= shreg;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && bus.dout_ready) begin
                dout_valid_r <= 1'b0;
            end

            if (bus.din_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.din) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg[cnt] <= bus.din;
                        if (cnt == CW'(WIDTH-1)) begin
`ifdef DESER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
`ifdef DESER_PARITY_EN
                    PARITY: begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        par_bad <= (bus.din != ^shreg);
                        state   <= STOP;
                    end
`endif
                    STOP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;
    assign bus.err_count  = err_count_r;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Randomized bench for serial_frame_deserializer; the reference model works per frame,
// knowing which driven bit is the stop bit and what word/parity the frame carried.
module tb_serial_frame_deserializer;
    localparam int W    = 8;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_frame_deserializer_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();
    serial_frame_deserializer #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    bit         exp_valid;
    logic [W-1:0] exp_dout;
    bit         exp_fe, exp_pe, exp_ov;
    int         exp_cnt;

    int rdy_mode;      // 0 random, 1 always ready, 2 never ready
    bit rdy_on_stop;   // force ready high on the stop-bit cycle
    int stall_max;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_valid = 0; exp_dout = '0; exp_fe = 0; exp_pe = 0; exp_ov = 0; exp_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        chk("dout",       32'(bus.dout),       32'(exp_dout));
        chk("frame_err",  32'(bus.frame_err),  32'(exp_fe));
        chk("parity_err", 32'(bus.parity_err), 32'(exp_pe));
        chk("overrun",    32'(bus.overrun),    32'(exp_ov));
        chk("err_count",  32'(bus.err_count),  32'(exp_cnt));
    endtask

    // One clock: check previous results, drive inputs, then advance the model at the edge.
    task automatic cycle(input logic b, input logic en, input bit is_stop,
                         input logic [W-1:0] d, input bit pbad);
        logic rdy;
        bit   old_v;
        @(negedge clk);
        check_outputs();
        case (rdy_mode)
            0:       rdy = 1'($urandom_range(0, 1));
            1:       rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        if (rdy_on_stop && is_stop && en) rdy = 1'b1;
        bus.din = b; bus.din_en = en; bus.dout_ready = rdy;
        @(posedge clk);
        old_v = exp_valid;
        exp_fe = 0; exp_pe = 0; exp_ov = 0;
        if (old_v && rdy) exp_valid = 0;
        if (en && is_stop) begin
            exp_fe = !b;
            exp_pe = pbad;
            if (b && !pbad) begin
                if (!old_v || rdy) begin
                    exp_dout  = d;
                    exp_valid = 1;
                end else begin
                    exp_ov = 1;
                end
            end
        end
        exp_cnt += int'(exp_fe) + int'(exp_pe) + int'(exp_ov);
        if (exp_cnt > EMAX) exp_cnt = EMAX;
    endtask

    task automatic put_bit(input logic b, input bit is_stop, input logic [W-1:0] d, input bit pbad);
        int n;
        n = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        repeat (n) cycle(1'($urandom_range(0, 1)), 1'b0, 0, '0, 0);
        cycle(b, 1'b1, is_stop, d, pbad);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b1, 0, '0, 0);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit pbad);
        bit pb;
`ifdef DESER_PARITY_EN
        pb = pbad;
`else
        pb = 0;
`endif
        put_bit(1'b0, 0, '0, 0);
        for (int i = 0; i < W; i++) put_bit(d[i], 0, '0, 0);
`ifdef DESER_PARITY_EN
        put_bit((^d) ^ pb, 0, '0, 0);
`endif
        put_bit(stop, 1, d, pb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout",       32'(bus.dout),       32'd0);
        chk("rst_pulses",     32'({bus.frame_err, bus.parity_err, bus.overrun}), 32'd0);
        chk("rst_err_count",  32'(bus.err_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.din = 1'b1; bus.din_en = 1'b0; bus.dout_ready = 1'b0;
        rdy_mode = 1; rdy_on_stop = 0; stall_max = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // basic delivery
        send_frame(8'hA5, 1'b1, 0);
        idle(3);
        // stop bit error
        send_frame(8'h3C, 1'b0, 0);
        idle(3);
        // overrun with full output register, then drain
        rdy_mode = 2;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        idle(2);
        rdy_mode = 1;
        idle(3);
        // register freed on the same edge the stop bit is sampled
        rdy_mode = 2;
        send_frame(8'h11, 1'b1, 0);
        idle(2);
        rdy_on_stop = 1;
        send_frame(8'h22, 1'b1, 0);
        rdy_on_stop = 0;
        rdy_mode = 1;
        idle(3);
        // reset mid-frame discards the partial word
        put_bit(1'b0, 0, '0, 0);
        repeat (4) put_bit(1'b1, 0, '0, 0);
        do_reset();
        send_frame(8'h5A, 1'b1, 0);
        idle(3);
        // saturate the error counter
        repeat (EMAX + 5) send_frame(W'($urandom), 1'b0, 0);
        idle(2);
`ifdef DESER_PARITY_EN
        send_frame(8'h07, 1'b1, 1);
        idle(2);
        send_frame(8'h07, 1'b0, 1);
        idle(2);
`endif
        do_reset();

        // randomized traffic with stalls and random backpressure
        rdy_mode = 0;
        stall_max = 2;
        for (int f = 0; f < 300; f++) begin
            send_frame(W'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0));
            if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(0, 2)));
            if (f == 150) do_reset();
        end
        rdy_mode = 1;
        idle(4);
        @(negedge clk);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
